// File: rtl/bram_frame_reader.sv
// Regenerates a timed video stream from a downscaled frame buffer in block RAM.
// Pixels and lines are replicated SCALE times; syncs/vde are delayed to match BRAM read latency.
module bram_frame_reader #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   SCALE    = 2,
  parameter int   BRAM_LAT = 2,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        pclk,
  input  logic        rstb,
  input  logic        en,
  output logic [23:0] bramaddr24b,
  output logic        bram_en,
  input  logic [23:0] bram_dout,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic        vde,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [1:0]  dbg_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SRC_W   = H_ACTIVE / SCALE;
  localparam int DLY     = BRAM_LAT + 1;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]    REP_LAST   = 8'(SCALE - 1);
  localparam logic [23:0]   LINE_STEP  = 24'(SRC_W);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state, state_next;
  logic [HW-1:0] h_cnt, src_col;
  logic [VW-1:0] v_cnt;
  logic [7:0]    hrep, vrep;
  logic [23:0]   line_base;
  logic          wrap, running, active, hs_raw, vs_raw, fs_raw;
  logic [DLY-1:0] vde_d, hs_d, vs_d, fs_d;

  // bram_en qualifies bramaddr24b; vde qualifies rgb. No backpressure exists on either side.
  assign wrap    = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign running = (state != IDLE);
  assign active  = running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw  = running && (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_raw  = running && (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign fs_raw  = active && (h_cnt == '0) && (v_cnt == '0);
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = wrap ? IDLE : DRAIN;
      DRAIN:   if (en) state_next = RUN;
               else if (wrap) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      src_col     <= '0;
      hrep        <= '0;
      vrep        <= '0;
      line_base   <= '0;
      bramaddr24b <= '0;
      bram_en     <= 1'b0;
    end else begin
      state   <= state_next;
      bram_en <= active;
      if (active) bramaddr24b <= line_base + 24'(src_col);
      if (!running || wrap) begin
        h_cnt     <= '0;
        v_cnt     <= '0;
        src_col   <= '0;
        hrep      <= '0;
        vrep      <= '0;
        line_base <= '0;
      end else begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
        // Replication: column advances every SCALE pixels, base advances every SCALE lines.
        if (active) begin
          if (h_cnt == H_ACT_LAST) begin
            src_col <= '0;
            hrep    <= '0;
            if (vrep == REP_LAST) begin
              vrep      <= '0;
              line_base <= line_base + LINE_STEP;
            end else begin
              vrep <= vrep + 1'b1;
            end
          end else if (hrep == REP_LAST) begin
            hrep    <= '0;
            src_col <= src_col + 1'b1;
          end else begin
            hrep <= hrep + 1'b1;
          end
        end
      end
    end
  end

  // Delay line depth covers the address register plus BRAM latency; the output register adds the last stage.
  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) begin
      vde_d       <= '0;
      hs_d        <= '0;
      vs_d        <= '0;
      fs_d        <= '0;
      vde         <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
      rgb_r       <= '0;
      rgb_g       <= '0;
      rgb_b       <= '0;
    end else begin
      vde_d       <= {vde_d[DLY-2:0], active};
      hs_d        <= {hs_d[DLY-2:0], hs_raw};
      vs_d        <= {vs_d[DLY-2:0], vs_raw};
      fs_d        <= {fs_d[DLY-2:0], fs_raw};
      vde         <= vde_d[DLY-1];
      hsync       <= hs_d[DLY-1] ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_d[DLY-1] ? SYNC_POL : ~SYNC_POL;
      frame_start <= fs_d[DLY-1];
      {rgb_r, rgb_g, rgb_b} <= vde_d[DLY-1] ? bram_dout : 24'd0;
    end
  end

endmodule

// File: tb/tb_bram_frame_reader.sv
// Bench for bram_frame_reader on a reduced raster (24x12 clocks): a 2x-scaled, latency-2 instance
// and a 1x, latency-1 instance run side by side against frame-pattern scoreboards.
module tb_bram_frame_reader;
  localparam int HA = 16, HF = 2, HS = 4, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 8, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic en = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] addr_a, dout_a, addr_b, dout_b;
  logic        ben_a, ben_b, vde_a, vde_b, hs_a, hs_b, vs_a, vs_b, fs_a, fs_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic [1:0]  st_a, st_b;
  logic [23:0] a_s0, a_s1, b_s0;

  bram_frame_reader #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SCALE(2), .BRAM_LAT(2)) dut_a (
    .pclk(clk), .rstb(rstb), .en(en), .bramaddr24b(addr_a), .bram_en(ben_a), .bram_dout(dout_a),
    .rgb_r(r_a), .rgb_g(g_a), .rgb_b(b_a), .vde(vde_a), .hsync(hs_a), .vsync(vs_a),
    .frame_start(fs_a), .dbg_state(st_a));

  bram_frame_reader #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SCALE(1), .BRAM_LAT(1)) dut_b (
    .pclk(clk), .rstb(rstb), .en(en), .bramaddr24b(addr_b), .bram_en(ben_b), .bram_dout(dout_b),
    .rgb_r(r_b), .rgb_g(g_b), .rgb_b(b_b), .vde(vde_b), .hsync(hs_b), .vsync(vs_b),
    .frame_start(fs_b), .dbg_state(st_b));

  // BRAM models: contents equal the address; a read without enable returns a marker value.
  always @(posedge clk) begin
    a_s0 <= ben_a ? addr_a : 24'hBAD000;
    a_s1 <= a_s0;
    b_s0 <= ben_b ? addr_b : 24'hBAD000;
  end
  assign dout_a = a_s1;
  assign dout_b = b_s0;

  int total = 0, bad = 0;
  logic [24:0] exp_a[$], exp_b[$];
  logic [23:0] adq_a[$], adq_b[$];
  int fsc_a[$];
  int fs_cnt_b = 0;
  int lat_a = -1, lat_b = -1;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_frame();
    int a, b;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) begin
        a = (y / 2) * (HA / 2) + x / 2;
        b = y * HA + x;
        exp_a.push_back({(x == 0 && y == 0), 24'(a)});
        adq_a.push_back(24'(a));
        exp_b.push_back({(x == 0 && y == 0), 24'(b)});
        adq_b.push_back(24'(b));
      end
  endtask

  task automatic clear_queues();
    exp_a.delete(); adq_a.delete(); exp_b.delete(); adq_b.delete();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_vde"}, vde_a, 0);
    chk({tag, "_rgb"}, {r_a, g_a, b_a}, 0);
    chk({tag, "_hsync"}, hs_a, 1);
    chk({tag, "_vsync"}, vs_a, 1);
    chk({tag, "_bram_en"}, ben_a, 0);
    chk({tag, "_addr"}, addr_a, 0);
    chk({tag, "_fs"}, fs_a, 0);
    chk({tag, "_state"}, st_a, 0);
    chk({tag, "_b_vde"}, vde_b, 0);
    chk({tag, "_b_bram_en"}, ben_b, 0);
    chk({tag, "_b_hsync"}, hs_b, 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, st_a, 0);
    chk({tag, "_vde"}, vde_a, 0);
    chk({tag, "_rgb"}, {r_a, g_a, b_a}, 0);
    chk({tag, "_hsync"}, hs_a, 1);
    chk({tag, "_vsync"}, vs_a, 1);
    chk({tag, "_bram_en"}, ben_a, 0);
    chk({tag, "_b_state"}, st_b, 0);
    chk({tag, "_b_vde"}, vde_b, 0);
  endtask

  // Monitor: raster timing plus scoreboard pops on every qualified output
  logic hs_prev = 1'b1, vs_prev = 1'b1, vde_prev = 1'b0, run_ok = 1'b0;
  int   hs_fall = -1, vs_fall = -1, run = 0;

  always @(negedge clk) begin
    logic [24:0] e;
    if (!rstb) begin
      hs_prev = 1'b1; vs_prev = 1'b1; vde_prev = 1'b0; run_ok = 1'b0;
      hs_fall = -1; vs_fall = -1; run = 0;
    end else begin
      if (vde_a) begin
        if (exp_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_vde: got vde=1 expected no pixel (cycle %0d)", cyc);
        end else begin
          e = exp_a.pop_front();
          chk("a_rgb", {r_a, g_a, b_a}, int'(e[23:0]));
          chk("a_frame_start", fs_a, int'(e[24]));
        end
      end else begin
        chk("a_rgb_blank", {r_a, g_a, b_a}, 0);
        chk("a_fs_blank", fs_a, 0);
      end
      if (fs_a) begin
        fsc_a.push_back(cyc);
        if (lat_a >= 0) begin chk("a_start_latency", cyc - lat_a, 5); lat_a = -1; end
      end
      if (ben_a) begin
        if (adq_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_bram_en: got addr %0d expected no read (cycle %0d)", addr_a, cyc);
        end else chk("a_addr", addr_a, int'(adq_a.pop_front()));
      end
      if (hs_prev && !hs_a) begin
        if (hs_fall >= 0 && cyc - hs_fall < 2 * HT) chk("a_hs_period", cyc - hs_fall, HT);
        hs_fall = cyc;
      end
      if (!hs_prev && hs_a && hs_fall >= 0) chk("a_hs_width", cyc - hs_fall, HS);
      if (vs_prev && !vs_a) vs_fall = cyc;
      if (!vs_prev && vs_a && vs_fall >= 0) chk("a_vs_width", cyc - vs_fall, VS * HT);
      if (vde_a && !vde_prev) begin run = 0; run_ok = 1'b1; end
      if (vde_a) run++;
      if (!vde_a && vde_prev && run_ok) chk("a_vde_run", run, HA);
      hs_prev = hs_a; vs_prev = vs_a; vde_prev = vde_a;

      if (vde_b) begin
        if (exp_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_vde: got vde=1 expected no pixel (cycle %0d)", cyc);
        end else begin
          e = exp_b.pop_front();
          chk("b_rgb", {r_b, g_b, b_b}, int'(e[23:0]));
          chk("b_frame_start", fs_b, int'(e[24]));
        end
      end else chk("b_fs_blank", fs_b, 0);
      if (fs_b) begin
        fs_cnt_b++;
        if (lat_b >= 0) begin chk("b_start_latency", cyc - lat_b, 4); lat_b = -1; end
      end
      if (ben_b) begin
        if (adq_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_bram_en: got addr %0d expected no read (cycle %0d)", addr_b, cyc);
        end else chk("b_addr", addr_b, int'(adq_b.pop_front()));
      end
    end
  end

  initial begin
    rstb = 1'b0;
    en = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_values("reset");
    en = 1'b0;
    rstb = 1'b1;
    repeat (5) @(negedge clk);
    chk_idle("idle_start");

    // Three back-to-back frames, en dropped on line 3 of the third
    repeat (3) push_frame();
    en = 1'b1; lat_a = cyc; lat_b = cyc;
    repeat (2 * FT + 3 * HT) @(negedge clk);
    chk("run_state", st_a, 1);
    en = 1'b0;
    @(negedge clk);
    chk("drain_state", st_a, 2);
    repeat (400) @(negedge clk);
    chk_idle("idle_after_drain");
    chk("a_queue_empty_1", exp_a.size(), 0);

    // Drain interrupted by en: frame 5 must follow frame 4 without a gap
    repeat (2) push_frame();
    en = 1'b1; lat_a = cyc; lat_b = cyc;
    repeat (100) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("drain_state_2", st_a, 2);
    repeat (49) @(negedge clk);
    en = 1'b1;
    repeat (200) @(negedge clk);
    en = 1'b0;
    repeat (400) @(negedge clk);
    chk("a_queue_empty_2", exp_a.size(), 0);
    chk("b_queue_empty_2", exp_b.size(), 0);

    // Asynchronous reset in the middle of active line 2
    push_frame();
    en = 1'b1; lat_a = cyc; lat_b = cyc;
    repeat (2 * HT + 4) @(negedge clk);
    chk("pre_reset_state", st_a, 1);
    #1 rstb = 1'b0;
    #1;
    chk_reset_values("midline_reset");
    clear_queues();
    repeat (3) @(negedge clk);
    push_frame();
    rstb = 1'b1; lat_a = cyc; lat_b = cyc;
    repeat (FT - 3 * HT) @(negedge clk);
    en = 1'b0;
    repeat (400) @(negedge clk);
    chk_idle("idle_end");

    chk("a_queue_empty_end", exp_a.size(), 0);
    chk("a_addr_queue_empty_end", adq_a.size(), 0);
    chk("b_queue_empty_end", exp_b.size(), 0);
    chk("b_addr_queue_empty_end", adq_b.size(), 0);
    chk("a_frame_count", fsc_a.size(), 7);
    chk("b_frame_count", fs_cnt_b, 7);
    if (fsc_a.size() >= 5) begin
      chk("a_frame_period_1", fsc_a[1] - fsc_a[0], FT);
      chk("a_frame_period_2", fsc_a[2] - fsc_a[1], FT);
      chk("a_idle_gap", int'(fsc_a[3] - fsc_a[2] > FT), 1);
      chk("a_no_gap_after_drain", fsc_a[4] - fsc_a[3], FT);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
